// File: rtl/rv32_imem_loader.sv
// ---------------------------------------------------------------------------
// rv32_imem_loader
//
// Takes a host word stream (header with length N, N payload words, one
// checksum word) and writes the payload into the instruction memory of
// rv32_core. The core is held in program mode and reset while loading. It is
// released only after the checksum matches, so it never runs a partial or
// corrupt image.
//
// Ports
//   rv32_io_clk, rv32_io_rst_n  clock; asynchronous active-low reset
//   ldr_start                   one-cycle load request (IDLE/ERROR only)
//   ldr_in_valid/ready/data     host stream
//   imem_w_en/addr/data         registered instruction-memory write port
//   core_program, core_rst_n    core control
//   ldr_busy                    load in progress (HDR..HOLD)
//   ldr_done                    one-cycle pulse when the core is released
//   ldr_err, ldr_err_code       sticky error: 1 zero length,
//                               2 too long, 3 checksum mismatch
//   dbg_state                   current FSM state, for observation
//
// Handshake: a word moves on every rising edge where ldr_in_valid and
// ldr_in_ready are both 1. ldr_in_ready is decoded from the state alone and
// never looks at ldr_in_valid. The host may raise or drop valid at any time.
// ---------------------------------------------------------------------------
module rv32_imem_loader #(
    parameter int IMEM_ADDR_W = 10,
    parameter int BASE_ADDR   = 0,
    parameter int RST_HOLD    = 4
) (
    input  logic                   rv32_io_clk,
    input  logic                   rv32_io_rst_n,
    input  logic                   ldr_start,
    input  logic                   ldr_in_valid,
    output logic                   ldr_in_ready,
    input  logic [31:0]            ldr_in_data,
    output logic                   imem_w_en,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_data,
    output logic                   core_program,
    output logic                   core_rst_n,
    output logic                   ldr_busy,
    output logic                   ldr_done,
    output logic                   ldr_err,
    output logic [1:0]             ldr_err_code,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_LOAD  = 3'd2,
        S_CSUM  = 3'd3,
        S_HOLD  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    // Largest legal payload length: the words from BASE_ADDR to the top of
    // memory. It is 33 bits wide, so 2^IMEM_ADDR_W cannot overflow.
    localparam logic [32:0]            LIMIT     = (33'd1 << IMEM_ADDR_W) - 33'(BASE_ADDR);
    localparam logic [IMEM_ADDR_W-1:0] BASE      = IMEM_ADDR_W'(BASE_ADDR);
    localparam logic [7:0]             HOLD_INIT = 8'(RST_HOLD);

    state_t      state, state_d;
    logic [31:0] len;
    logic [31:0] cnt;
    logic [31:0] sum;
    logic [7:0]  hold_cnt;

    logic        xfer;
    logic [31:0] cnt_inc;
    logic        go_start, go_hdr, go_wr, go_hold, go_err, go_release;
    logic [1:0]  err_code_d;

    assign xfer      = ldr_in_valid && ldr_in_ready;
    assign cnt_inc   = cnt + 32'd1;
    assign dbg_state = state;

    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        go_start     = 1'b0;
        go_hdr       = 1'b0;
        go_wr        = 1'b0;
        go_hold      = 1'b0;
        go_err       = 1'b0;
        go_release   = 1'b0;
        err_code_d   = 2'd0;
        ldr_in_ready = 1'b0;
        ldr_busy     = 1'b0;
        case (state)
            S_IDLE, S_ERROR: begin
                if (ldr_start) begin
                    state_d  = S_HDR;
                    go_start = 1'b1;
                end
            end
            S_HDR: begin
                ldr_in_ready = 1'b1;
                ldr_busy     = 1'b1;
                if (xfer) begin
                    go_hdr = 1'b1;
                    if (ldr_in_data == 32'd0) begin
                        state_d    = S_ERROR;
                        go_err     = 1'b1;
                        err_code_d = 2'd1;
                    end else if ({1'b0, ldr_in_data} > LIMIT) begin
                        state_d    = S_ERROR;
                        go_err     = 1'b1;
                        err_code_d = 2'd2;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                ldr_in_ready = 1'b1;
                ldr_busy     = 1'b1;
                if (xfer) begin
                    go_wr = 1'b1;
                    if (cnt_inc == len) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                ldr_in_ready = 1'b1;
                ldr_busy     = 1'b1;
                if (xfer) begin
                    if (ldr_in_data == sum) begin
                        state_d = S_HOLD;
                        go_hold = 1'b1;
                    end else begin
                        state_d    = S_ERROR;
                        go_err     = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
            end
            S_HOLD: begin
                ldr_busy = 1'b1;
                if (hold_cnt == 8'd0) begin
                    state_d    = S_IDLE;
                    go_release = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rv32_io_clk or negedge rv32_io_rst_n) begin
        if (!rv32_io_rst_n) begin
            len          <= '0;
            cnt          <= '0;
            sum          <= '0;
            hold_cnt     <= '0;
            imem_w_en    <= 1'b0;
            imem_addr    <= '0;
            imem_data    <= '0;
            core_program <= 1'b0;
            core_rst_n   <= 1'b0;
            ldr_done     <= 1'b0;
            ldr_err      <= 1'b0;
            ldr_err_code <= 2'd0;
        end else begin
            imem_w_en <= go_wr;
            ldr_done  <= go_release;

            if (go_start) begin
                ldr_err      <= 1'b0;
                ldr_err_code <= 2'd0;
                core_rst_n   <= 1'b0;
                core_program <= 1'b1;
                cnt          <= '0;
                sum          <= '0;
            end

            if (go_hdr) begin
                len <= ldr_in_data;
            end

            // The length check bounds the address, so the low bits of cnt
            // are enough and the address never wraps.
            if (go_wr) begin
                imem_addr <= BASE + cnt[IMEM_ADDR_W-1:0];
                imem_data <= ldr_in_data;
                sum       <= sum + ldr_in_data;
                cnt       <= cnt_inc;
            end

            if (go_hold) begin
                hold_cnt     <= HOLD_INIT;
                core_program <= 1'b0;
            end else if (state == S_HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end

            if (go_release) begin
                core_rst_n <= 1'b1;
            end

            if (go_err) begin
                ldr_err      <= 1'b1;
                ldr_err_code <= err_code_d;
                core_program <= 1'b0;
                core_rst_n   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv32_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_rv32_imem_loader
//
// Directed sequence of loads against rv32_imem_loader with the default
// parameters (1024-word memory, base 0, hold 4). Payloads are random or
// taken from fixed tables. Expected writes, checksums, error codes and
// release timing come from the stream rules: addr = BASE + i, and
// checksum = payload sum mod 2^32.
// ---------------------------------------------------------------------------
module tb_rv32_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;
    localparam int BASE  = 0;
    localparam int HOLD  = 4;
    localparam int W     = AW + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          ldr_start = 1'b0;
    logic          ldr_in_valid = 1'b0;
    logic          ldr_in_ready;
    logic [31:0]   ldr_in_data = '0;
    logic          imem_w_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          core_program, core_rst_n, ldr_busy, ldr_done, ldr_err;
    logic [1:0]    ldr_err_code;
    logic [2:0]    dbg_state;

    rv32_imem_loader #(.IMEM_ADDR_W(AW), .BASE_ADDR(BASE), .RST_HOLD(HOLD)) dut (
        .rv32_io_clk   (clk),
        .rv32_io_rst_n (rst_n),
        .ldr_start     (ldr_start),
        .ldr_in_valid  (ldr_in_valid),
        .ldr_in_ready  (ldr_in_ready),
        .ldr_in_data   (ldr_in_data),
        .imem_w_en     (imem_w_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .core_program  (core_program),
        .core_rst_n    (core_rst_n),
        .ldr_busy      (ldr_busy),
        .ldr_done      (ldr_done),
        .ldr_err       (ldr_err),
        .ldr_err_code  (ldr_err_code),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] pay[$];
    logic [31:0] tb_mem [0:DEPTH-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-side monitor: every write must match the next expected write.
    always @(negedge clk) begin
        if (imem_w_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 64'(imem_addr), 64'hFFFF_FFFF);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[W-1:32]));
                chk("wr_data", 64'(imem_data), 64'(e[31:0]));
            end
            tb_mem[imem_addr] = imem_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rst_n"},   64'(core_rst_n),   64'd0);
        chk({tag, "_prog"},    64'(core_program), 64'd0);
        chk({tag, "_wen"},     64'(imem_w_en),    64'd0);
        chk({tag, "_addr"},    64'(imem_addr),    64'd0);
        chk({tag, "_data"},    64'(imem_data),    64'd0);
        chk({tag, "_ready"},   64'(ldr_in_ready), 64'd0);
        chk({tag, "_busy"},    64'(ldr_busy),     64'd0);
        chk({tag, "_done"},    64'(ldr_done),     64'd0);
        chk({tag, "_err"},     64'(ldr_err),      64'd0);
        chk({tag, "_errcode"}, 64'(ldr_err_code), 64'd0);
    endtask

    // All driver tasks start and end at a falling edge.
    task automatic raw_start();
        ldr_start = 1'b1;
        @(negedge clk);
        ldr_start = 1'b0;
    endtask

    task automatic pulse_start();
        raw_start();
        chk("start_ready", 64'(ldr_in_ready), 64'd1);
        chk("start_busy",  64'(ldr_busy),     64'd1);
        chk("start_rst_n", 64'(core_rst_n),   64'd0);
        chk("start_prog",  64'(core_program), 64'd1);
        chk("start_err",   64'(ldr_err),      64'd0);
        chk("start_code",  64'(ldr_err_code), 64'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        int k;
        ldr_in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        ldr_in_valid = 1'b1;
        ldr_in_data  = w;
        k = 0;
        while (ldr_in_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", 64'(ldr_in_ready), 64'd1);
        @(negedge clk);
        ldr_in_valid = 1'b0;
    endtask

    task automatic send_payload(input int i, input int gap);
        exp_q.push_back({AW'(BASE + i), pay[i]});
        send_word(pay[i], gap);
        chk("wr_latency", 64'(imem_w_en), 64'd1);
    endtask

    // One full load from pay[]. A wrong checksum is the true sum plus one.
    task automatic run_load(input int gap_max, input bit bad_cs, input bit start_mid);
        logic [31:0] s;
        int n;
        n = pay.size();
        s = '0;
        foreach (pay[i]) s = s + pay[i];
        if (bad_cs) s = s + 32'd1;
        pulse_start();
        send_word(32'(n), $urandom_range(0, gap_max));
        chk("hdr_err", 64'(ldr_err), 64'd0);
        for (int i = 0; i < n; i++) begin
            send_payload(i, $urandom_range(0, gap_max));
            if (start_mid && i == 0) begin
                raw_start();
                chk("ignored_start_busy", 64'(ldr_busy), 64'd1);
            end
        end
        send_word(s, $urandom_range(0, gap_max));
        chk("cs_prog", 64'(core_program), 64'd0);
        if (bad_cs) begin
            chk("bad_err",   64'(ldr_err),      64'd1);
            chk("bad_code",  64'(ldr_err_code), 64'd3);
            chk("bad_busy",  64'(ldr_busy),     64'd0);
            for (int j = 0; j < HOLD + 3; j++) begin
                chk("bad_rst_n", 64'(core_rst_n), 64'd0);
                chk("bad_done",  64'(ldr_done),   64'd0);
                @(negedge clk);
            end
        end else begin
            // Checksum edge t: release lands on edge t+1+HOLD.
            for (int j = 0; j <= HOLD; j++) begin
                chk("hold_rst_n", 64'(core_rst_n), 64'd0);
                chk("hold_done",  64'(ldr_done),   64'd0);
                chk("hold_busy",  64'(ldr_busy),   64'd1);
                @(negedge clk);
            end
            chk("rel_done",  64'(ldr_done),   64'd1);
            chk("rel_rst_n", 64'(core_rst_n), 64'd1);
            chk("rel_err",   64'(ldr_err),    64'd0);
            chk("rel_busy",  64'(ldr_busy),   64'd0);
            @(negedge clk);
            chk("post_done",  64'(ldr_done),   64'd0);
            chk("post_rst_n", 64'(core_rst_n), 64'd1);
            for (int i = 0; i < n; i++) begin
                if (tb_mem[BASE + i] !== pay[i])
                    chk("image", 64'(tb_mem[BASE + i]), 64'(pay[i]));
            end
            chk("image_words", 64'(n), 64'(pay.size()));
        end
        chk("wr_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_len_err(input logic [31:0] n, input logic [1:0] code);
        pulse_start();
        send_word(n, 0);
        chk("len_err",   64'(ldr_err),      64'd1);
        chk("len_code",  64'(ldr_err_code), 64'(code));
        chk("len_rst_n", 64'(core_rst_n),   64'd0);
        chk("len_prog",  64'(core_program), 64'd0);
        chk("len_ready", 64'(ldr_in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("len_sticky", 64'(ldr_err), 64'd1);
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back($urandom);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        foreach (tb_mem[i]) tb_mem[i] = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rst_n", 64'(core_rst_n), 64'd0);

        // Fixed image, no backpressure.
        pay = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8113};
        run_load(0, 1'b0, 1'b0);

        // Same image with gaps between transfers.
        run_load(2, 1'b0, 1'b0);

        // Bad checksum, then a good load clears the error.
        pay = '{32'd1, 32'd2};
        run_load(0, 1'b1, 1'b0);
        rand_pay(6);
        run_load(1, 1'b0, 1'b0);

        // Length errors: zero, one past depth, far too long.
        run_len_err(32'd0, 2'd1);
        run_len_err(32'd1025, 2'd2);
        run_len_err(32'hFFFF_FFFF, 2'd2);

        // Start pulsed mid-load is ignored.
        rand_pay(5);
        run_load(1, 1'b0, 1'b1);

        // Reset after 2 of 5 payload words, then a full restart.
        rand_pay(5);
        pulse_start();
        send_word(32'd5, 0);
        send_payload(0, 0);
        send_payload(1, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_q", 64'(exp_q.size()), 64'd0);
        run_load(1, 1'b0, 1'b0);

        // Random lengths and data.
        for (int r = 0; r < 4; r++) begin
            rand_pay($urandom_range(1, 20));
            run_load(2, 1'b0, 1'b0);
        end

        // Exact-fit image covering the whole memory.
        rand_pay(DEPTH);
        run_load(0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
